// File: rtl/pwm_ramp_ctrl_if.sv
// pwm_ramp_ctrl_if: command handshake and duty/status bundle between control logic and pwm_ramp_ctrl.
interface pwm_ramp_ctrl_if #(
  parameter int N = 4,
  parameter int DIV_W = 16
);
  logic cmd_valid_i;
  logic cmd_ready_o;
  logic mode_i;
  logic [N-1:0] target_i;
  logic [N-1:0] step_i;
  logic [DIV_W-1:0] dwell_i;
  logic stop_i;
  logic [N-1:0] pw_o;
  logic period_start_o;
  logic busy_o;
  logic done_o;
  modport master (
    output cmd_valid_i, mode_i, target_i, step_i, dwell_i, stop_i,
    input cmd_ready_o, pw_o, period_start_o, busy_o, done_o
  );
  modport slave (
    input cmd_valid_i, mode_i, target_i, step_i, dwell_i, stop_i,
    output cmd_ready_o, pw_o, period_start_o, busy_o, done_o
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: period-aligned duty ramp/breathe sequencer for an N-bit PWM core.
// Optional PWM_GAMMA_EN: square-law output curve applied to the linear duty register.
module pwm_ramp_ctrl #(
  parameter int N = 4,
  parameter int DIV_W = 16
) (
  input logic clk_i,
  input logic reset_i,
  pwm_ramp_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, UP, DOWN, EQ, HOLD_HI, BR_DOWN, HOLD_LO} state_t;
  state_t r_state;
  logic [N-1:0] r_cnt, r_pw, r_tgt, r_step;
  logic [DIV_W-1:0] r_dwell, r_dw_cnt;
  logic r_mode, r_stop, r_done;
  logic w_tick, w_fire, w_stepping, w_reach, w_stop;
  logic [N-1:0] w_goal, w_up, w_dn, w_nx;
  assign w_tick = &r_cnt;
  assign w_fire = w_tick && (r_dw_cnt == r_dwell - DIV_W'(1));
  assign w_goal = (r_state == BR_DOWN) ? '0 : r_tgt;
  assign w_up = (({1'b0, r_tgt} - {1'b0, r_pw}) <= {1'b0, r_step}) ? r_tgt : r_pw + r_step;
  assign w_dn = (({1'b0, r_pw} - {1'b0, w_goal}) <= {1'b0, r_step}) ? w_goal : r_pw - r_step;
  assign w_nx = (r_state == UP) ? w_up : w_dn;
  assign w_reach = (w_nx == w_goal);
  assign w_stepping = (r_state == UP) || (r_state == DOWN) || (r_state == BR_DOWN);
  assign w_stop = r_stop | bus.stop_i;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_pw <= '0;
      r_tgt <= '0;
      r_step <= '0;
      r_dwell <= '0;
      r_dw_cnt <= '0;
      r_mode <= 1'b0;
      r_stop <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_cnt <= r_cnt + N'(1);
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        r_stop <= 1'b0;
        if (bus.cmd_valid_i) begin
          r_tgt <= bus.target_i;
          r_step <= (bus.step_i == '0) ? N'(1) : bus.step_i;
          r_dwell <= (bus.dwell_i == '0) ? DIV_W'(1) : bus.dwell_i;
          r_mode <= bus.mode_i;
          r_dw_cnt <= '0;
          r_state <= (bus.target_i > r_pw) ? UP : (bus.target_i < r_pw) ? DOWN : bus.mode_i ? HOLD_HI : EQ;
        end
      end else begin
        if (bus.stop_i) r_stop <= 1'b1;
        if (w_tick) begin
          r_dw_cnt <= w_fire ? '0 : r_dw_cnt + DIV_W'(1);
          if (r_state == EQ) begin
            r_done <= !w_stop;
            r_state <= IDLE;
          end else if (w_fire && (r_state == UP || r_state == DOWN) && w_reach && !r_mode) begin
            // a final step wins over a concurrent stop
            r_pw <= w_nx;
            r_done <= 1'b1;
            r_state <= IDLE;
          end else if (w_stop) begin
            r_state <= IDLE;
          end else if (w_fire) begin
            if (w_stepping) r_pw <= w_nx;
            r_state <= (r_state == HOLD_HI) ? BR_DOWN : (r_state == HOLD_LO) ? UP :
                       !w_reach ? r_state : (r_state == BR_DOWN) ? HOLD_LO : HOLD_HI;
          end
        end
      end
    end
  end
`ifdef PWM_GAMMA_EN
  logic [2*N-1:0] w_sq;
  assign w_sq = {{N{1'b0}}, r_pw} * {{N{1'b0}}, r_pw};
  assign bus.pw_o = w_sq[2*N-1:N];
`else
  assign bus.pw_o = r_pw;
`endif
  assign bus.period_start_o = (r_cnt == '0);
  assign bus.busy_o = (r_state != IDLE);
  assign bus.cmd_ready_o = (r_state == IDLE);
  assign bus.done_o = r_done;
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed ramp/breathe scenarios checked against a duty-plan model every cycle.
module tb_pwm_ramp_ctrl;
  localparam int N = 4;
  localparam int DIV_W = 16;
  logic clk = 0;
  logic rst = 0;
  bit run = 0;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  pwm_ramp_ctrl_if #(.N(N), .DIV_W(DIV_W)) bus();
  pwm_ramp_ctrl #(.N(N), .DIV_W(DIV_W)) dut (.clk_i(clk), .reset_i(rst), .bus(bus));
  function automatic int g(int x);
`ifdef PWM_GAMMA_EN
    return (x * x) >> N;
`else
    return x;
`endif
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask
  int m_cnt, m_pw, m_tgt, m_step, m_dwell, m_per;
  bit m_busy, m_done, m_mode, m_stop, m_eq, m_tick;
  int m_plan[$];
  function automatic void ramp_to(int a, int b, int s);
    while (a != b) begin
      a = (b > a) ? ((b - a <= s) ? b : a + s) : ((a - b <= s) ? b : a - s);
      m_plan.push_back(a);
    end
  endfunction
  function automatic void add_cycle();
    m_plan.push_back(m_tgt);
    ramp_to(m_tgt, 0, m_step);
    m_plan.push_back(0);
    ramp_to(0, m_tgt, m_step);
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_pw = 0; m_busy = 0; m_done = 0; m_stop = 0; m_eq = 0; m_per = 0;
      m_plan.delete();
    end else begin
      m_tick = (m_cnt == (1 << N) - 1);
      m_cnt = (m_cnt + 1) % (1 << N);
      m_done = 0;
      if (!m_busy) begin
        if (bus.cmd_valid_i) begin
          m_mode = bus.mode_i;
          m_tgt = int'(bus.target_i);
          m_step = (bus.step_i == 0) ? 1 : int'(bus.step_i);
          m_dwell = (bus.dwell_i == 0) ? 1 : int'(bus.dwell_i);
          m_per = 0; m_stop = 0; m_busy = 1;
          m_eq = !m_mode && (m_tgt == m_pw);
          m_plan.delete();
          ramp_to(m_pw, m_tgt, m_step);
          if (m_mode) add_cycle();
        end
      end else begin
        if (bus.stop_i) m_stop = 1;
        if (m_tick) begin
          if (m_eq) begin
            m_done = !m_stop; m_busy = 0; m_eq = 0;
          end else begin
            m_per++;
            if (m_per == m_dwell && !m_mode && m_plan.size() == 1) begin
              m_pw = m_plan.pop_front(); m_done = 1; m_busy = 0;
            end else if (m_stop) begin
              m_busy = 0;
            end else if (m_per == m_dwell) begin
              m_pw = m_plan.pop_front(); m_per = 0;
              if (m_plan.size() == 0) add_cycle();
            end
          end
        end
      end
    end
  end
  always @(posedge clk) begin
    #1;
    if (!rst && run) begin
      chk("pw_o", 32'(bus.pw_o), 32'(g(m_pw)));
      chk("busy_o", 32'(bus.busy_o), 32'(m_busy));
      chk("cmd_ready_o", 32'(bus.cmd_ready_o), 32'(!m_busy));
      chk("done_o", 32'(bus.done_o), 32'(m_done));
      chk("period_start_o", 32'(bus.period_start_o), 32'(m_cnt == 0));
    end
  end
  task automatic send(bit md, int t, int s, int d);
    @(negedge clk);
    bus.mode_i = md; bus.target_i = N'(t); bus.step_i = N'(s); bus.dwell_i = DIV_W'(d);
    bus.cmd_valid_i = 1;
    @(negedge clk);
    bus.cmd_valid_i = 0;
  endtask
  task automatic expect_ps(string nm, int pw, bit dn);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.period_start_o) begin
        chk({nm, "_pw"}, 32'(bus.pw_o), 32'(g(pw)));
        chk({nm, "_done"}, 32'(bus.done_o), 32'(dn));
        return;
      end
    end
    n_chk++; n_err++;
    $display("FAIL %s period_start timeout actual=0 required=1", nm);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.cmd_valid_i = 0; bus.mode_i = 0; bus.target_i = 0; bus.step_i = 0; bus.dwell_i = 0; bus.stop_i = 0;
    #1 rst = 1;
    #20;
    @(negedge clk) rst = 0;
    #1;
    chk("rst_period_start", 32'(bus.period_start_o), 32'd1);
    chk("rst_pw", 32'(bus.pw_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_ready", 32'(bus.cmd_ready_o), 32'd1);
    run = 1;
    send(0, 8, 3, 1);
    expect_ps("up1", 3, 0);
    expect_ps("up2", 6, 0);
    expect_ps("up3", 8, 1);
    chk("up_ready", 32'(bus.cmd_ready_o), 32'd1);
    send(0, 2, 4, 2);
    expect_ps("dn1", 8, 0);
    expect_ps("dn2", 4, 0);
    expect_ps("dn3", 4, 0);
    expect_ps("dn4", 2, 1);
    send(0, 4, 0, 0);
    expect_ps("z1", 3, 0);
    expect_ps("z2", 4, 1);
    send(0, 4, 2, 5);
    expect_ps("eq", 4, 1);
    send(0, 0, 15, 1);
    expect_ps("clr", 0, 1);
    send(1, 15, 5, 1);
    expect_ps("br1", 5, 0);
    expect_ps("br2", 10, 0);
    expect_ps("br3", 15, 0);
    expect_ps("br4", 15, 0);
    expect_ps("br5", 10, 0);
    expect_ps("br6", 5, 0);
    expect_ps("br7", 0, 0);
    expect_ps("br8", 0, 0);
    expect_ps("br9", 5, 0);
    expect_ps("br10", 10, 0);
    @(negedge clk) bus.stop_i = 1;
    @(negedge clk) bus.stop_i = 0;
    expect_ps("stop", 10, 0);
    chk("stop_busy", 32'(bus.busy_o), 32'd0);
    send(0, 14, 1, 1);
    expect_ps("bsy1", 11, 0);
    @(negedge clk);
    bus.target_i = 0; bus.cmd_valid_i = 1;
    repeat (3) @(negedge clk);
    bus.cmd_valid_i = 0;
    expect_ps("bsy2", 12, 0);
    expect_ps("bsy3", 13, 0);
    expect_ps("bsy4", 14, 1);
    send(1, 15, 5, 1);
    expect_ps("pre1", 15, 0);
    expect_ps("pre2", 15, 0);
    expect_ps("pre3", 10, 0);
    @(negedge clk) rst = 1;
    #1;
    chk("arst_pw", 32'(bus.pw_o), 32'd0);
    chk("arst_busy", 32'(bus.busy_o), 32'd0);
    chk("arst_ready", 32'(bus.cmd_ready_o), 32'd1);
    chk("arst_done", 32'(bus.done_o), 32'd0);
    @(negedge clk) rst = 0;
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
